// File: rtl/udc_host_ctrl_if.sv
// rtl/udc_host_ctrl_if.sv - register-bus and control signals between host controller and up/down counter
interface udc_host_ctrl_if;
  logic       udc_reset;
  logic       ncs;
  logic       nwr;
  logic       nrd;
  logic       a1;
  logic       a0;
  logic       start;
  logic [7:0] cout;
  logic       err;
  logic       ec;

  modport master (
    output udc_reset, ncs, nwr, nrd, a1, a0, start,
    input  cout, err, ec
  );

  modport slave (
    input  udc_reset, ncs, nwr, nrd, a1, a0, start,
    output cout, err, ec
  );
endinterface

// File: rtl/udc_host_ctrl.sv
// rtl/udc_host_ctrl.sv - sequencer that programs, verifies and runs the up/down counter per host command
module udc_host_ctrl #(
  parameter int RD_WAIT     = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [7:0]          cmd_plr,
  input  logic [7:0]          cmd_ulr,
  input  logic [7:0]          cmd_llr,
  input  logic [7:0]          cmd_ccr,
  output logic                busy,
  output logic                done,
  output logic [2:0]          status,
  output logic [7:0]          result_cout,
  udc_host_ctrl_if.master     bus,
  inout  wire  [7:0]          din
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WR, S_RD, S_CHK, S_START, S_WAIT, S_DONE
  } state_t;

  localparam logic [2:0]  ST_OK       = 3'd0;
  localparam logic [2:0]  ST_ERR      = 3'd1;
  localparam logic [2:0]  ST_MISMATCH = 3'd2;
  localparam logic [2:0]  ST_TIMEOUT  = 3'd3;
  localparam logic [2:0]  ST_ZERO     = 3'd4;
  localparam logic [1:0]  RD_LAST     = 2'(RD_WAIT);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  rcnt;
  logic [15:0] tcnt;
  logic [7:0]  val [4];
  logic        mism;
  logic        ncs_q, nwr_q, nrd_q, start_q, udc_reset_q;
  logic [1:0]  addr;
  logic [7:0]  wdata;

  assign bus.ncs       = ncs_q;
  assign bus.nwr       = nwr_q;
  assign bus.nrd       = nrd_q;
  assign bus.a1        = addr[1];
  assign bus.a0        = addr[0];
  assign bus.start     = start_q;
  assign bus.udc_reset = udc_reset_q;
  assign din           = nwr_q ? 8'bz : wdata;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      idx         <= '0;
      rcnt        <= '0;
      tcnt        <= '0;
      for (int i = 0; i < 4; i++) val[i] <= '0;
      mism        <= 1'b0;
      ncs_q       <= 1'b1;
      nwr_q       <= 1'b1;
      nrd_q       <= 1'b1;
      start_q     <= 1'b0;
      udc_reset_q <= 1'b1;
      addr        <= '0;
      wdata       <= '0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= ST_OK;
      result_cout <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ncs_q <= 1'b1;
          // The first cycle out of reset only drops udc_reset; commands open a cycle later.
          if (udc_reset_q) begin
            udc_reset_q <= 1'b0;
          end else if (cmd_valid && cmd_ready) begin
            val[0]      <= cmd_plr;
            val[1]      <= cmd_ulr;
            val[2]      <= cmd_llr;
            val[3]      <= cmd_ccr;
            mism        <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            ncs_q       <= 1'b0;
            udc_reset_q <= 1'b1;
            state       <= S_RST;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_RST: begin
          udc_reset_q <= 1'b0;
          nwr_q       <= 1'b0;
          addr        <= 2'd0;
          wdata       <= val[0];
          idx         <= 2'd0;
          state       <= S_WR;
        end
        S_WR: begin
          if (idx == 2'd3) begin
            nwr_q <= 1'b1;
            nrd_q <= 1'b0;
            addr  <= 2'd0;
            idx   <= 2'd0;
            rcnt  <= 2'd0;
            state <= S_RD;
          end else begin
            idx   <= idx + 2'd1;
            addr  <= idx + 2'd1;
            wdata <= val[idx + 2'd1];
          end
        end
        S_RD: begin
          if (rcnt != RD_LAST) begin
            rcnt <= rcnt + 2'd1;
          end else begin
            if (din != val[idx]) mism <= 1'b1;
            rcnt <= 2'd0;
            if (idx == 2'd3) begin
              nrd_q <= 1'b1;
              state <= S_CHK;
            end else begin
              idx  <= idx + 2'd1;
              addr <= idx + 2'd1;
            end
          end
        end
        S_CHK: begin
          if (mism || bus.err || (val[3] == 8'd0)) begin
            status      <= mism ? ST_MISMATCH : (bus.err ? ST_ERR : ST_ZERO);
            result_cout <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
            ncs_q       <= 1'b1;
            state       <= S_DONE;
          end else begin
            start_q <= 1'b1;
            tcnt    <= '0;
            state   <= S_START;
          end
        end
        S_START: begin
          // tcnt counts cycles since the start pulse, so timeout lands TIMEOUT_CYC cycles after it.
          start_q <= 1'b0;
          tcnt    <= tcnt + 16'd1;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ec) begin
            status      <= ST_OK;
            result_cout <= bus.cout;
            done        <= 1'b1;
            busy        <= 1'b0;
            ncs_q       <= 1'b1;
            state       <= S_DONE;
          end else if (tcnt == TO_LAST) begin
            status      <= ST_TIMEOUT;
            result_cout <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
            ncs_q       <= 1'b1;
            state       <= S_DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udc_host_ctrl.sv
// tb/tb_udc_host_ctrl.sv - directed bench: two controllers (RD_WAIT 2 and 0) driving behavioural counters
module tb_udc_host_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_plr = '0, cmd_ulr = '0, cmd_llr = '0, cmd_ccr = '0;
  logic       ec_en = 1'b1;
  logic       corrupt = 1'b0;
  logic       clr = 1'b0;
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        done_a [2], busy_a [2], ready_a [2];
  logic        ncs_a [2], nwr_a [2], nrd_a [2], start_a [2], ureset_a [2];
  logic [1:0]  addr_a [2];
  logic [2:0]  status_a [2];
  logic [7:0]  result_a [2];
  logic [31:0] regs_a [2];
  int start_cnt_a [2], start_cyc_a [2], done_cnt_a [2], done_cyc_a [2];
  int acc_cyc_a [2], viol_a [2], wr_cnt_a [2], rd_cyc_a [2];

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int RWG = (g == 0) ? 2 : 0;
    udc_host_ctrl_if bif ();
    wire  [7:0] din;
    logic       done, busy, cmd_ready;
    logic [2:0] status;
    logic [7:0] result_cout;

    udc_host_ctrl #(.RD_WAIT(RWG), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .nreset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_plr(cmd_plr), .cmd_ulr(cmd_ulr), .cmd_llr(cmd_llr), .cmd_ccr(cmd_ccr),
      .busy(busy), .done(done), .status(status), .result_cout(result_cout),
      .bus(bif), .din(din)
    );

    logic [7:0] regs [4] = '{default: 8'h00};
    logic [3:0] ec_cnt = 4'd0;
    wire  [1:0] a = {bif.a1, bif.a0};

    always @(posedge clk) begin
      if (bif.udc_reset) regs <= '{default: 8'h00};
      else if (!bif.ncs && !bif.nwr) regs[a] <= din;
      if (bif.start) ec_cnt <= 4'd3;
      else if (ec_cnt != 4'd0) ec_cnt <= ec_cnt - 4'd1;
    end

    assign din      = !bif.nrd ? (regs[a] ^ ((corrupt && a == 2'd1) ? 8'h01 : 8'h00)) : 8'bz;
    assign bif.cout = regs[0];
    assign bif.err  = (regs[0] > regs[1]) || (regs[0] < regs[2]);
    assign bif.ec   = ec_en && (ec_cnt == 4'd1);

    int start_cnt = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0;
    int acc_cyc = 0, viol = 0, wr_cnt = 0, rd_cyc = 0;

    always @(negedge clk) begin
      if (clr) begin
        start_cnt = 0; start_cyc = 0; done_cnt = 0; done_cyc = 0;
        acc_cyc = 0; viol = 0; wr_cnt = 0; rd_cyc = 0;
      end else begin
        if (bif.start) begin start_cnt++; start_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (!bif.nwr && !bif.nrd) viol++;
        if (!bif.ncs && !bif.nwr) wr_cnt++;
        if (!bif.nrd) rd_cyc++;
      end
    end

    assign done_a[g] = done;        assign busy_a[g] = busy;       assign ready_a[g] = cmd_ready;
    assign ncs_a[g] = bif.ncs;      assign nwr_a[g] = bif.nwr;     assign nrd_a[g] = bif.nrd;
    assign start_a[g] = bif.start;  assign ureset_a[g] = bif.udc_reset;
    assign addr_a[g] = a;           assign status_a[g] = status;   assign result_a[g] = result_cout;
    assign regs_a[g] = {regs[3], regs[2], regs[1], regs[0]};
    assign start_cnt_a[g] = start_cnt; assign start_cyc_a[g] = start_cyc;
    assign done_cnt_a[g] = done_cnt;   assign done_cyc_a[g] = done_cyc;
    assign acc_cyc_a[g] = acc_cyc;     assign viol_a[g] = viol;
    assign wr_cnt_a[g] = wr_cnt;       assign rd_cyc_a[g] = rd_cyc;
  end

  function automatic int rw_of(input int g);
    return (g == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, g, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    for (int g = 0; g < 2; g++) begin
      check({pfx, "_ncs"}, g, ncs_a[g], 1);
      check({pfx, "_nwr"}, g, nwr_a[g], 1);
      check({pfx, "_nrd"}, g, nrd_a[g], 1);
      check({pfx, "_addr"}, g, addr_a[g], 0);
      check({pfx, "_start"}, g, start_a[g], 0);
      check({pfx, "_udc_reset"}, g, ureset_a[g], 1);
      check({pfx, "_cmd_ready"}, g, ready_a[g], 0);
      check({pfx, "_busy"}, g, busy_a[g], 0);
      check({pfx, "_done"}, g, done_a[g], 0);
      check({pfx, "_status"}, g, status_a[g], 0);
      check({pfx, "_result"}, g, result_a[g], 0);
    end
  endtask

  task automatic send_cmd(input logic [7:0] p, input logic [7:0] uu, input logic [7:0] l, input logic [7:0] c);
    bit ok;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 clr = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready_a[0] && ready_a[1]) begin ok = 1; break; end
    end
    check("ready_wait", 0, ok, 1);
    @(posedge clk);
    #1;
    cmd_plr = p; cmd_ulr = uu; cmd_llr = l; cmd_ccr = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_plr = 8'hAA; cmd_ulr = 8'hAA; cmd_llr = 8'hAA; cmd_ccr = 8'hAA;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt_a[0] > 0 && done_cnt_a[1] > 0) begin ok = 1; break; end
    end
    check("done_wait", 0, ok, 1);
  endtask

  task automatic check_cmd(input logic [2:0] st, input logic [7:0] res, input int starts, input logic [31:0] regs);
    for (int g = 0; g < 2; g++) begin
      check("status", g, status_a[g], st);
      check("result_cout", g, result_a[g], res);
      check("start_pulses", g, start_cnt_a[g], starts);
      check("done_pulses", g, done_cnt_a[g], 1);
      check("write_cycles", g, wr_cnt_a[g], 4);
      check("read_cycles", g, rd_cyc_a[g], 4 * (rw_of(g) + 1));
      check("strobe_overlap", g, viol_a[g], 0);
      check("counter_regs", g, regs_a[g], regs);
    end
  endtask

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rel_udc_reset", g, ureset_a[g], 0);
      check("rel_ready_low", g, ready_a[g], 0);
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check("idle_ready", g, ready_a[g], 1);

    // Normal run: ec 3 cycles into WAIT, so latency = 1+4+4*(RW+1)+1+1+3+1
    ec_en = 1'b1; corrupt = 1'b0;
    send_cmd(8'd5, 8'd15, 8'd1, 8'd1);
    wait_done();
    check_cmd(3'd0, 8'd5, 1, 32'h01010F05);
    for (int g = 0; g < 2; g++)
      check("latency", g, done_cyc_a[g] - acc_cyc_a[g], 11 + 4 * (rw_of(g) + 1));
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("ready_after_done", g, ready_a[g], 1);
      check("busy_after_done", g, busy_a[g], 0);
    end

    // Range error
    send_cmd(8'd20, 8'd15, 8'd1, 8'd1);
    wait_done();
    check_cmd(3'd1, 8'd0, 0, 32'h01010F14);

    // Zero CCR
    send_cmd(8'd9, 8'd9, 8'd9, 8'd0);
    wait_done();
    check_cmd(3'd4, 8'd0, 0, 32'h00090909);

    // Timeout
    ec_en = 1'b0;
    send_cmd(8'd5, 8'd15, 8'd1, 8'd1);
    wait_done();
    check_cmd(3'd3, 8'd0, 1, 32'h01010F05);
    for (int g = 0; g < 2; g++)
      check("timeout_cycles", g, done_cyc_a[g] - start_cyc_a[g], 64);

    // Readback mismatch on ULR
    ec_en = 1'b1; corrupt = 1'b1;
    send_cmd(8'd5, 8'd15, 8'd1, 8'd1);
    wait_done();
    check_cmd(3'd2, 8'd0, 0, 32'h01010F05);

    // Abort in WAIT
    corrupt = 1'b0; ec_en = 1'b0;
    send_cmd(8'd7, 8'd20, 8'd3, 8'd2);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start_cnt_a[0] == 1 && start_cnt_a[1] == 1) begin ok = 1; break; end
    end
    check("abort_start_seen", 0, ok, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset("abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check("abort_no_done", g, done_cnt_a[g], 0);

    ec_en = 1'b1;
    send_cmd(8'd1, 8'd2, 8'd1, 8'd5);
    wait_done();
    check_cmd(3'd0, 8'd1, 1, 32'h05010201);
    for (int g = 0; g < 2; g++)
      check("latency_post_abort", g, done_cyc_a[g] - acc_cyc_a[g], 11 + 4 * (rw_of(g) + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
